// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM encoding, keymap and
// column-decode helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebPress,
    StPressed,
    StDebRelease
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Indexed by {row, col}; entry 0 (row 0, col 0) is the rightmost nibble.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, KEY_HASH, 4'h0, KEY_STAR,
    4'hC, 4'h9,     4'h8, 4'h7,
    4'hB, 4'h6,     4'h5, 4'h4,
    4'hA, 4'h3,     4'h2, 4'h1
  };

  // True when exactly one active-low column is asserted.
  function automatic logic single_low(input logic [3:0] v);
    return $countones(~v) == 1;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_4x4_if.sv
// Keypad pin and key-code bundle; master is the scanner, slave is the pins/user side.
interface keypad_scanner_4x4_if;

  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_pressed;

  modport master (
    output row_n,
    output key,
    output key_valid,
    output key_pressed,
    input  col_n
  );

  modport slave (
    input  row_n,
    input  key,
    input  key_valid,
    input  key_pressed,
    output col_n
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones so
// active-low pulled-up inputs read as idle.
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: strobes rows, debounces a single column hit and emits
// one key_valid pulse per accepted press with the mapped hex code.
module keypad_scanner_4x4
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV         = 12000,
  parameter int unsigned DEBOUNCE_SAMPLES = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  keypad_scanner_4x4_if.master  bus
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_SAMPLES);

  logic [3:0]      col_s;
  logic [DivW-1:0] div_q;
  logic            tick;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]      row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic            hit, col_low;
  logic            accept, release_done;

  logic [3:0]      key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic            key_pressed_q, key_pressed_d;

  sync_2ff #(
    .WIDTH (4)
  ) u_col_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.col_n),
    .q       (col_s)
  );

  // Row dwell divider; every decision below happens only on tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick    = (div_q == DivLast);
  assign hit     = single_low(col_s);
  assign col_low = ~col_s[col_q];
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StScan;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    accept       = 1'b0;
    release_done = 1'b0;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (hit) begin
            col_d   = low_index(col_s);
            cnt_d   = CntW'(1);
            state_d = StDebPress;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
        StDebPress: begin
          if (hit && col_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntDone) begin
              state_d = StPressed;
              accept  = 1'b1;
            end
          end else begin
            state_d = StScan;
            cnt_d   = '0;
            row_d   = row_q + 1'b1;
          end
        end
        StPressed: begin
          // Other keys in the frozen row are ignored; only the latched column matters.
          if (!col_low) begin
            cnt_d   = CntW'(1);
            state_d = StDebRelease;
          end
        end
        StDebRelease: begin
          if (!col_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntDone) begin
              state_d      = StScan;
              cnt_d        = '0;
              row_d        = row_q + 1'b1;
              release_done = 1'b1;
            end
          end else begin
            state_d = StPressed;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StScan;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_d         = key_q;
    key_valid_d   = accept;
    key_pressed_d = key_pressed_q;
    if (accept) begin
      key_d         = KEYMAP[{row_q, col_q}];
      key_pressed_d = 1'b1;
    end
    if (release_done) begin
      key_pressed_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_q         <= 4'h0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      key_q         <= key_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign bus.row_n       = ~(4'b0001 << row_q);
  assign bus.key         = key_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_pressed = key_pressed_q;

endmodule

// File: doc/keypad_scanner_4x4.md
Name: keypad_scanner_4x4

Overview:
Scans a 4x4 matrix keypad on pio pins and produces a debounced 4-bit hex key code. This is the input-side counterpart of the hex-to-seven-segment display path: a key press yields the number that the display driver shows. The block drives rows, samples columns, debounces, rejects multi-key ghosting, and emits one valid pulse per press. It sits between the pio GPIO pins and user logic in the top level.

Parameters:
SCAN_DIV, 12000 (1 ms at 12 MHz), clock cycles per row dwell; minimum 4.
DEBOUNCE_SAMPLES, 10, consecutive identical tick samples required for press and for release; minimum 2.

Ports:
clock  input  1  system clock, 12 MHz
reset_n  input  1  reset, asynchronous, active-low
row_n  output  4  row strobes, active-low, exactly one bit low at any time
col_n  input  4  raw column inputs, active-low, externally pulled up, asynchronous
key  output  4  hex code of the last accepted key
key_valid  output  1  one-cycle pulse when a new key is accepted
key_pressed  output  1  level, high from acceptance until debounced release

Behaviour:
- Reset values: row_n=4'b1110 (row 0), key=4'h0, key_valid=0, key_pressed=0, state=SCAN, divider=0, debounce count=0, synchronizer flops=4'b1111.
- col_n passes through a 2-flop synchronizer. All decisions use the synchronized value col_s.
- Divider counts 0..SCAN_DIV-1 and wraps. tick is a 1-cycle pulse when the divider equals SCAN_DIV-1.
- col_s is evaluated only on tick. The row has then been stable for SCAN_DIV cycles, which exceeds the synchronizer latency.
- "single hit" means exactly one bit of col_s is low. Zero or two-plus low bits count as no hit (ghost rejection).
- Keymap, code = {row,col} lookup:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D, with *=E and #=F
- State machine (all transitions on tick only):
  - SCAN:
    - single hit: latch row/col, cnt=1, go to DEB_PRESS. The row stays frozen.
    - otherwise: advance row 0->1->2->3->0 (rotate the low bit left).
  - DEB_PRESS:
    - single hit on the latched column: cnt++.
    - when cnt reaches DEBOUNCE_SAMPLES: go to PRESSED. On the next clock edge, key=code, key_valid=1 for exactly one cycle, key_pressed=1.
    - any other sample: go to SCAN and advance row. No pulse.
  - PRESSED:
    - latched column bit high in col_s: cnt=1, go to DEB_RELEASE.
    - otherwise: stay. A second key pressed in the same row is ignored.
  - DEB_RELEASE:
    - latched column high: cnt++.
    - when cnt reaches DEBOUNCE_SAMPLES: go to SCAN, key_pressed=0, advance row.
    - latched column low again: go to PRESSED with no new pulse (treated as bounce).
- key holds its value after release until the next acceptance.
- Latency: key_valid asserts 1 clock after the DEBOUNCE_SAMPLES-th qualifying tick.
- Counter widths: divider $clog2(SCAN_DIV); cnt $clog2(DEBOUNCE_SAMPLES+1). No wrap is possible because cnt saturates at the compare value.
- Reset asserted mid-operation returns immediately to the reset values. A key still held after reset is re-detected and produces a fresh pulse.

Decomposition:
- Package keypad_pkg holds:
  - state encoding: SCAN, DEB_PRESS, PRESSED, DEB_RELEASE
  - 16-entry keymap constant indexed by {row,col}
  - codes KEY_STAR=4'hE, KEY_HASH=4'hF
- One sub-module, sync_2ff, parameterised by width (4 here) with reset value all-ones. It is reusable for pio button inputs.

Test Plan:
- Setup for all scenarios:
  - Parameters: SCAN_DIV=4, DEBOUNCE_SAMPLES=3.
  - Keypad model: col_n[c] = ~|(pressed[r][c] & ~row_n[r]).
- Reset with no keys -> row_n=1110, key=0, key_valid=0, key_pressed=0. Then row_n steps 1101, 1011, 0111, 1110 every 4 cycles.
- Hold key '5' (row1,col1) for 40 cycles -> row_n freezes at 1101, exactly one key_valid pulse, key=4'h5, key_pressed=1. After release, key_pressed falls after 3 high ticks and key stays 5.
- Press '8' (row2,col1) for 2 ticks only, then release -> no key_valid, key unchanged, scanning resumes.
- Hold '4' and '6' simultaneously (both row1) -> no key_valid ever. Press '*', then '#', then 'D' separately -> codes E, F, D, one pulse each.
- Accepted '0', then a 1-tick release glitch mid-hold -> key_pressed stays 1, no second pulse. A full release followed by a re-press -> second pulse, key=0.
- Assert reset_n=0 while in PRESSED with '9' held, then deassert -> outputs go to reset values at once; '9' is re-accepted with one new pulse.
